player_lane_ctrl: RTL and testbench
===================================

// Module: player_lane_ctrl
// PURPOSE
//   Parametrised player controller for the bottom display row. Moves the player cell
//   across COLS columns from joystick left/right, with edge-triggered steps and
//   hold-to-repeat. Fires coloured bullets on joystick press through a valid/ready
//   handshake to the bullet manager. Emits the packed player row and the player
//   position as one-hot for debug LEDs.
// PARAMETERS
//   COLS       8    number of columns; player position range 0..COLS-1
//   CW         5    colour code width per cell
//   DARK       31   colour code of an empty cell
//   NCOLORS    3    bullet colour palette size (codes COLOR_BASE..COLOR_BASE+NCOLORS-1)
//   COLOR_BASE 10   first palette code
//   RST_POS    1    player column after reset
//   REPEAT     4    ticks a direction must stay held before each repeat step (>=1)
//   COOLDOWN   3    ticks after shot acceptance before the next press is honoured (>=0)
//   WRAP       0    0: saturate at column 0/COLS-1; 1: wrap around
// PORTS
//   clk         in   1           system clock
//   rst         in   1           synchronous, active-high reset
//   en          in   1           game running; low freezes movement and new shots
//   tick        in   1           one-cycle game-tick strobe (replaces divided clock)
//   jstk_left   in   1           joystick left level (moves toward higher column)
//   jstk_right  in   1           joystick right level (moves toward lower column)
//   jstk_press  in   1           joystick button level
//   player_row  out  COLS*CW     cell c at [c*CW +: CW]; player cell = cur_color, others DARK
//   shot_valid  out  1           bullet request pending
//   shot_ready  in   1           bullet manager accepts when valid&&ready
//   shot_col    out  clog2(COLS) column of pending bullet (stable while valid)
//   shot_color  out  CW          colour of pending bullet (stable while valid)
//   pos_onehot  out  COLS        one-hot player column (debug)
// BEHAVIOUR
//   Reset: pos=RST_POS; player_row = all DARK; shot_valid=0; shot_col=0; shot_color=DARK;
//     cur_color=COLOR_BASE; LFSR=8'h01; cooldown=0; state IDLE; inputs' history regs = 0.
//   player_row and pos_onehot are registered from pos/cur_color: 1-cycle lag after any change.
//   Movement (en=1): dir = left XOR right; left&&right or neither -> no move, repeat cnt=0.
//     Rising edge of active dir -> step same cycle it is sampled (pos updates next clk),
//     repeat cnt cleared. While held: cnt++ on each tick; at cnt==REPEAT step, cnt=0.
//     Bound: WRAP=0 saturates (no step, no error); WRAP=1 COLS-1+1 -> 0, 0-1 -> COLS-1.
//   LFSR: 8-bit Galois (taps 8,6,5,4), advances every clk incl. en=0, never zero.
//   Shooter FSM:
//     IDLE: press rising edge && en -> FIRE; latch shot_col=pos, shot_color=cur_color;
//           shot_valid=1 next cycle. Same-cycle move: shot uses pre-move pos.
//     FIRE: hold valid/col/color until valid&&ready; on accept: valid=0,
//           cur_color = COLOR_BASE + (LFSR % NCOLORS), cooldown=COOLDOWN,
//           go COOL (or IDLE if COOLDOWN==0). en low does NOT drop a pending shot.
//     COOL: cooldown-- on each tick; at 0 -> IDLE. Presses ignored (not queued).
//   Press held continuously fires once; a new rising edge is required.
//   rst mid-operation: pending shot discarded, all state to reset values next cycle.
//   en=0: pos, repeat cnt, cooldown frozen; edge history still tracks inputs (no
//     spurious edge when en returns).
// TESTING
//   T1 reset, RST_POS=1: after rst, row all 31 for 1 cycle, then cell1=10, rest 31;
//      pos_onehot=8'b0000_0010.
//   T2 left pulse x7 from pos1, WRAP=0: pos 2..7 then stays 7; WRAP=1: 7 -> 0.
//   T3 right held 13 ticks, REPEAT=4: 1 step on edge + 3 repeat steps (saturates at 0).
//   T4 press at pos3, shot_ready low 5 cycles: shot_valid stays 1, shot_col=3 stable
//      while player moves to 4; accept -> valid=0 next cycle, cur_color in 10..12.
//   T5 COOLDOWN=3: second press 1 tick after accept ignored; press after 3 ticks fires.
//   T6 rst asserted while FIRE: shot_valid=0 next cycle, pos=RST_POS; left&&right -> no move.

Source files
------------

// File: rtl/player_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : player_lane_ctrl
// Brief   : Bottom-row player controller. It moves the player from joystick
//           input with hold-to-repeat and fires coloured shots over valid/ready.
// Rev     : 1.0  initial release
// ============================================================================
module player_lane_ctrl #(
    parameter int COLS       = 8,
    parameter int CW         = 5,
    parameter int DARK       = 31,
    parameter int NCOLORS    = 3,
    parameter int COLOR_BASE = 10,
    parameter int RST_POS    = 1,
    parameter int REPEAT     = 4,
    parameter int COOLDOWN   = 3,
    parameter int WRAP       = 0,
    localparam int c_PW      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 tick,
    input  logic                 jstk_left,
    input  logic                 jstk_right,
    input  logic                 jstk_press,
    output logic [COLS*CW-1:0]   player_row,
    output logic                 shot_valid,
    input  logic                 shot_ready,
    output logic [c_PW-1:0]      shot_col,
    output logic [CW-1:0]        shot_color,
    output logic [COLS-1:0]      pos_onehot
);

    localparam int c_RW  = $clog2(REPEAT + 1);
    localparam int c_CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [c_PW-1:0]  c_LAST    = c_PW'(COLS - 1);
    localparam logic [c_PW-1:0]  c_RST_POS = c_PW'(RST_POS);
    localparam logic [CW-1:0]    c_DARK    = CW'(DARK);
    localparam logic [CW-1:0]    c_BASE    = CW'(COLOR_BASE);
    localparam logic [c_RW-1:0]  c_RPT_TOP = c_RW'(REPEAT - 1);
    localparam logic [c_CDW-1:0] c_CD_INIT = c_CDW'(COOLDOWN);
    localparam logic [COLS-1:0]  c_ONE     = COLS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_COOL = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic                left_q, right_q, press_q;
    logic [c_PW-1:0]     pos_q, pos_d;
    logic [c_RW-1:0]     rcnt_q, rcnt_d;
    logic [c_CDW-1:0]    cool_q, cool_d;
    logic [7:0]          lfsr_q, lfsr_d;
    logic [CW-1:0]       cur_color_q, cur_color_d;
    logic                shot_valid_q, shot_valid_d;
    logic [c_PW-1:0]     shot_col_q, shot_col_d;
    logic [CW-1:0]       shot_color_q, shot_color_d;
    logic [COLS*CW-1:0]  row_q, row_d;
    logic [COLS-1:0]     onehot_q, onehot_d;

    logic                w_dir_l, w_dir_r, w_prev_l, w_prev_r;
    logic                w_rise, w_step, w_press_rise;
    logic [c_PW-1:0]     w_pos_up, w_pos_dn;
    logic [31:0]         w_mod;
    logic [CW-1:0]       w_next_color;

    // A direction is active only when exactly one side is held.
    assign w_dir_l      = jstk_left & ~jstk_right;
    assign w_dir_r      = jstk_right & ~jstk_left;
    assign w_prev_l     = left_q & ~right_q;
    assign w_prev_r     = right_q & ~left_q;
    assign w_rise       = (w_dir_l & ~w_prev_l) | (w_dir_r & ~w_prev_r);
    assign w_press_rise = jstk_press & ~press_q;

    assign w_pos_up = (pos_q == c_LAST) ? ((WRAP != 0) ? '0 : pos_q)
                                        : pos_q + c_PW'(1);
    assign w_pos_dn = (pos_q == '0) ? ((WRAP != 0) ? c_LAST : pos_q)
                                    : pos_q - c_PW'(1);

    assign w_mod        = {24'd0, lfsr_q} % 32'(NCOLORS);
    assign w_next_color = c_BASE + CW'(w_mod);

    // Movement: immediate step on a new direction, then one step per REPEAT ticks.
    always_comb begin
        pos_d  = pos_q;
        rcnt_d = rcnt_q;
        w_step = 1'b0;
        if (en) begin
            if (!(w_dir_l || w_dir_r)) begin
                rcnt_d = '0;
            end else if (w_rise) begin
                w_step = 1'b1;
                rcnt_d = '0;
            end else if (tick) begin
                if (rcnt_q == c_RPT_TOP) begin
                    w_step = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + c_RW'(1);
                end
            end
        end
        if (w_step) begin
            pos_d = w_dir_l ? w_pos_up : w_pos_dn;
        end
    end

    // Galois form of x^8+x^6+x^5+x^4+1; free-running regardless of en.
    assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

    always_comb begin
        state_d      = state_q;
        shot_valid_d = shot_valid_q;
        shot_col_d   = shot_col_q;
        shot_color_d = shot_color_q;
        cur_color_d  = cur_color_q;
        cool_d       = cool_q;
        case (state_q)
            S_IDLE: begin
                // Shot captures the pre-move position even if a step lands this cycle.
                if (en && w_press_rise) begin
                    state_d      = S_FIRE;
                    shot_valid_d = 1'b1;
                    shot_col_d   = pos_q;
                    shot_color_d = cur_color_q;
                end
            end
            S_FIRE: begin
                if (shot_ready) begin
                    shot_valid_d = 1'b0;
                    cur_color_d  = w_next_color;
                    cool_d       = c_CD_INIT;
                    state_d      = (COOLDOWN == 0) ? S_IDLE : S_COOL;
                end
            end
            S_COOL: begin
                if (en && tick) begin
                    if (cool_q <= c_CDW'(1)) begin
                        cool_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        cool_d = cool_q - c_CDW'(1);
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                shot_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        row_d = '0;
        for (int c = 0; c < COLS; c++) begin
            row_d[c*CW +: CW] = (pos_q == c_PW'(c)) ? cur_color_q : c_DARK;
        end
        onehot_d = c_ONE << pos_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            press_q      <= 1'b0;
            pos_q        <= c_RST_POS;
            rcnt_q       <= '0;
            cool_q       <= '0;
            lfsr_q       <= 8'h01;
            cur_color_q  <= c_BASE;
            shot_valid_q <= 1'b0;
            shot_col_q   <= '0;
            shot_color_q <= c_DARK;
            row_q        <= {COLS{c_DARK}};
            onehot_q     <= '0;
        end else begin
            left_q       <= jstk_left;
            right_q      <= jstk_right;
            press_q      <= jstk_press;
            pos_q        <= pos_d;
            rcnt_q       <= rcnt_d;
            cool_q       <= cool_d;
            lfsr_q       <= lfsr_d;
            cur_color_q  <= cur_color_d;
            shot_valid_q <= shot_valid_d;
            shot_col_q   <= shot_col_d;
            shot_color_q <= shot_color_d;
            row_q        <= row_d;
            onehot_q     <= onehot_d;
        end
    end

    assign player_row = row_q;
    assign pos_onehot = onehot_q;
    assign shot_valid = shot_valid_q;
    assign shot_col   = shot_col_q;
    assign shot_color = shot_color_q;

endmodule
`default_nettype wire

// File: tb/tb_player_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_player_lane_ctrl
// Brief   : Self-checking bench for player_lane_ctrl (saturating and wrapping
//           instances driven by the same stimulus; shots checked by scoreboard).
// Rev     : 1.0  initial release
// ============================================================================
module tb_player_lane_ctrl;

    localparam int COLS       = 8;
    localparam int CW         = 5;
    localparam int DARK       = 31;
    localparam int NCOLORS    = 3;
    localparam int COLOR_BASE = 10;
    localparam int RST_POS    = 1;
    localparam int REPEAT     = 4;
    localparam int COOLDOWN   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic tick = 1'b0;
    logic jstk_left = 1'b0;
    logic jstk_right = 1'b0;
    logic jstk_press = 1'b0;
    logic shot_ready = 1'b0;

    logic [COLS*CW-1:0] player_row, w_player_row;
    logic               shot_valid, w_shot_valid;
    logic [2:0]         shot_col, w_shot_col;
    logic [CW-1:0]      shot_color, w_shot_color;
    logic [COLS-1:0]    pos_onehot, w_pos_onehot;

    int n_total = 0;
    int n_bad   = 0;
    int m_pos, m_wpos, cur_color, exp_c;
    logic [7:0] m_lfsr;

    typedef struct {
        int col;
        int color;
    } shot_t;
    shot_t sb_q[$];

    always #5 clk = ~clk;

    player_lane_ctrl #(.WRAP(0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick),
        .jstk_left(jstk_left), .jstk_right(jstk_right), .jstk_press(jstk_press),
        .player_row(player_row), .shot_valid(shot_valid), .shot_ready(shot_ready),
        .shot_col(shot_col), .shot_color(shot_color), .pos_onehot(pos_onehot)
    );

    player_lane_ctrl #(.WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .tick(tick),
        .jstk_left(jstk_left), .jstk_right(jstk_right), .jstk_press(jstk_press),
        .player_row(w_player_row), .shot_valid(w_shot_valid), .shot_ready(shot_ready),
        .shot_col(w_shot_col), .shot_color(w_shot_color), .pos_onehot(w_pos_onehot)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference palette source, x^8+x^6+x^5+x^4+1 Galois generator.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'h01;
        else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    end

    // Handshake monitor: every accepted shot must match the oldest expectation.
    always @(negedge clk) begin
        shot_t e;
        if (!rst && shot_valid && shot_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_shot", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("shot_col", 64'(shot_col), 64'(e.col));
                chk("shot_color", 64'(shot_color), 64'(e.color));
            end
        end
    end

    function automatic int step_pos(input int p, input int dir, input int wrap);
        if (dir > 0) return (p == COLS - 1) ? ((wrap != 0) ? 0 : p) : p + 1;
        return (p == 0) ? ((wrap != 0) ? COLS - 1 : p) : p - 1;
    endfunction

    function automatic logic [COLS*CW-1:0] exp_row(input int p, input int color);
        logic [COLS*CW-1:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++) r[c*CW +: CW] = (c == p) ? CW'(color) : CW'(DARK);
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_pulse();
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    endtask

    task automatic check_pos(input string tag);
        chk(tag, 64'(pos_onehot), 64'(1) << m_pos);
        chk({tag, "_wrap"}, 64'(w_pos_onehot), 64'(1) << m_wpos);
    endtask

    task automatic pulse_left();
        jstk_left = 1'b1; cyc(1); jstk_left = 1'b0; cyc(1);
        m_pos  = step_pos(m_pos, 1, 0);
        m_wpos = step_pos(m_wpos, 1, 1);
    endtask

    task automatic held_run(input int dir, input int nticks);
        int cnt;
        cnt = 0;
        if (dir > 0) jstk_left = 1'b1;
        else         jstk_right = 1'b1;
        cyc(1);
        m_pos  = step_pos(m_pos, dir, 0);
        m_wpos = step_pos(m_wpos, dir, 1);
        for (int k = 0; k < nticks; k++) begin
            tick_pulse();
            cnt++;
            if (cnt == REPEAT) begin
                m_pos  = step_pos(m_pos, dir, 0);
                m_wpos = step_pos(m_wpos, dir, 1);
                cnt    = 0;
            end
            check_pos("held");
        end
        jstk_left  = 1'b0;
        jstk_right = 1'b0;
        cyc(1);
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        en  = 1'b1;

        // Reset state, then registered view one cycle later
        chk("rst_row", 64'(player_row), 64'(exp_row(-1, 0)));
        chk("rst_onehot", 64'(pos_onehot), 64'd0);
        chk("rst_valid", 64'(shot_valid), 64'd0);
        chk("rst_col", 64'(shot_col), 64'd0);
        chk("rst_color", 64'(shot_color), 64'(DARK));
        cyc(1);
        m_pos = RST_POS; m_wpos = RST_POS; cur_color = COLOR_BASE;
        chk("row_after_rst", 64'(player_row), 64'(exp_row(m_pos, cur_color)));
        check_pos("rst_pos");

        // Single-step left to the edge: saturate vs wrap
        repeat (7) begin
            pulse_left();
            check_pos("left_pulse");
        end

        // Hold right with repeat, twice (second run hits column 0)
        held_run(-1, 13);
        held_run(-1, 13);
        repeat (3) begin
            pulse_left();
            check_pos("back_left");
        end

        // en low freezes movement and shots; no spurious edge on re-enable
        en = 1'b0;
        jstk_left = 1'b1; cyc(1); jstk_left = 1'b0; cyc(1);
        check_pos("en0_move");
        jstk_press = 1'b1; cyc(1); jstk_press = 1'b0; cyc(1);
        chk("en0_shot", 64'(shot_valid), 64'd0);
        jstk_left = 1'b1; cyc(1);
        en = 1'b1; cyc(2);
        check_pos("en_return");
        jstk_left = 1'b0; cyc(1);

        // Shot held against backpressure while the player moves
        sb_q.push_back('{m_pos, cur_color});
        jstk_press = 1'b1; cyc(1); jstk_press = 1'b0;
        chk("fire_valid", 64'(shot_valid), 64'd1);
        pulse_left();
        chk("bp_valid", 64'(shot_valid), 64'd1);
        chk("bp_col", 64'(shot_col), 64'd3);
        cyc(2);
        chk("bp_valid2", 64'(shot_valid), 64'd1);
        chk("bp_col2", 64'(shot_col), 64'd3);
        check_pos("bp_moved");
        exp_c = COLOR_BASE + int'(m_lfsr) % NCOLORS;
        shot_ready = 1'b1; cyc(1); shot_ready = 1'b0;
        chk("acc_valid", 64'(shot_valid), 64'd0);
        cur_color = exp_c;
        cyc(1);
        chk("new_color_row", 64'(player_row), 64'(exp_row(m_pos, cur_color)));

        // Cooldown: press after one tick ignored, press after COOLDOWN ticks fires
        tick_pulse();
        jstk_press = 1'b1; cyc(1); jstk_press = 1'b0; cyc(2);
        chk("cool_ignore", 64'(shot_valid), 64'd0);
        repeat (COOLDOWN - 1) tick_pulse();
        sb_q.push_back('{m_pos, cur_color});
        jstk_press = 1'b1; cyc(1);
        chk("cool_fire", 64'(shot_valid), 64'd1);
        exp_c = COLOR_BASE + int'(m_lfsr) % NCOLORS;
        shot_ready = 1'b1; cyc(1); shot_ready = 1'b0;
        cur_color = exp_c;
        chk("acc2_valid", 64'(shot_valid), 64'd0);
        repeat (COOLDOWN) tick_pulse();
        cyc(3);
        chk("held_press_once", 64'(shot_valid), 64'd0);
        jstk_press = 1'b0; cyc(1);
        chk("color2_row", 64'(player_row), 64'(exp_row(m_pos, cur_color)));

        // Reset while a shot is pending; both directions held afterwards
        jstk_press = 1'b1; cyc(1); jstk_press = 1'b0;
        chk("t6_pending", 64'(shot_valid), 64'd1);
        rst = 1'b1; jstk_left = 1'b1; jstk_right = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_valid", 64'(shot_valid), 64'd0);
        chk("t6_col", 64'(shot_col), 64'd0);
        chk("t6_color", 64'(shot_color), 64'(DARK));
        chk("t6_row", 64'(player_row), 64'(exp_row(-1, 0)));
        m_pos = RST_POS; m_wpos = RST_POS; cur_color = COLOR_BASE;
        repeat (3) tick_pulse();
        check_pos("both_held");
        chk("t6_row2", 64'(player_row), 64'(exp_row(m_pos, cur_color)));
        jstk_left = 1'b0; jstk_right = 1'b0;
        cyc(2);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
